// File: rtl/bus_sequencer.sv
// Instruction sequencer for the 8-bit register/bus datapath: fetches bytes over req/ack,
// then issues a drive phase followed by a capture phase, and resolves conditional jumps.
module bus_sequencer #(
  parameter logic [7:0]  RESET_PC      = 8'h00,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic [7:0] code_addr,
  output logic       code_rd_req,
  input  logic       code_rd_ack,
  input  logic [7:0] code_data,
  input  logic [7:0] cond_value,
  input  logic [7:0] jump_target,
  output logic [7:0] load_en,
  output logic [7:0] save_en,
  output logic       alu_sel,
  output logic [2:0] alu_order,
  output logic       imm_sel,
  output logic [5:0] imm_value,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRIVE,
    WRITE,
    FAULT
  } state_t;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ALU = 2'b01;
  localparam logic [1:0] OP_IMM = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [7:0] LAST_WAIT = 8'(FETCH_TIMEOUT - 1);

  state_t     state;
  state_t     nxt_state;
  logic [7:0] instr;
  logic [7:0] nxt_instr;
  logic [7:0] pc;
  logic [7:0] nxt_pc;
  logic [7:0] wait_cnt;
  logic [7:0] nxt_wait_cnt;

  logic [7:0] nxt_load;
  logic [7:0] nxt_save;
  logic       nxt_alu;
  logic       nxt_imm;
  logic       nxt_exec;

  // Upper cond bit inverts the base test: never/==0/<0/<=0 become always/!=0/>=0/>0.
  function automatic logic cond_holds(input logic [2:0] cond, input logic [7:0] value);
    logic zero;
    logic neg;
    logic base;
    zero = (value == 8'h00);
    neg  = value[7];
    case (cond[1:0])
      2'b00:   base = 1'b0;
      2'b01:   base = zero;
      2'b10:   base = neg;
      default: base = neg | zero;
    endcase
    return cond[2] ? ~base : base;
  endfunction

  always_comb begin
    nxt_state    = state;
    nxt_instr    = instr;
    nxt_pc       = pc;
    nxt_wait_cnt = wait_cnt;
    case (state)
      IDLE: begin
        if (run) begin
          nxt_state    = FETCH;
          nxt_wait_cnt = 8'h00;
        end
      end
      FETCH: begin
        if (code_rd_ack) begin
          nxt_instr    = code_data;
          nxt_wait_cnt = 8'h00;
          nxt_state    = DRIVE;
        end else if (wait_cnt == LAST_WAIT) begin
          nxt_state = FAULT;
        end else begin
          nxt_wait_cnt = wait_cnt + 8'h01;
        end
      end
      DRIVE: begin
        if (instr[7:6] == OP_JMP) begin
          nxt_pc    = cond_holds(instr[2:0], cond_value) ? jump_target : pc + 8'h01;
          nxt_state = run ? FETCH : IDLE;
        end else begin
          nxt_state = WRITE;
        end
      end
      WRITE: begin
        nxt_pc    = pc + 8'h01;
        nxt_state = run ? FETCH : IDLE;
      end
      FAULT: begin
        nxt_state = FAULT;
      end
      default: begin
        nxt_state = FAULT;
      end
    endcase
  end

  // Strobes are decoded from the upcoming state so they come straight out of flops.
  always_comb begin
    nxt_load = 8'h00;
    nxt_save = 8'h00;
    nxt_alu  = 1'b0;
    nxt_imm  = 1'b0;
    nxt_exec = (nxt_state == DRIVE) || (nxt_state == WRITE);
    if (nxt_exec) begin
      case (nxt_instr[7:6])
        OP_MOV: begin
          nxt_load = 8'b1 << nxt_instr[5:3];
          if (nxt_state == WRITE) nxt_save = 8'b1 << nxt_instr[2:0];
        end
        OP_ALU: begin
          nxt_alu = 1'b1;
          if (nxt_state == WRITE) nxt_save = 8'h08;
        end
        OP_IMM: begin
          nxt_imm = 1'b1;
          if (nxt_state == WRITE) nxt_save = 8'h01;
        end
        default: begin
          nxt_load = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr       <= 8'h00;
      pc          <= RESET_PC;
      wait_cnt    <= 8'h00;
      code_addr   <= RESET_PC;
      code_rd_req <= 1'b0;
      load_en     <= 8'h00;
      save_en     <= 8'h00;
      alu_sel     <= 1'b0;
      alu_order   <= 3'b000;
      imm_sel     <= 1'b0;
      imm_value   <= 6'b000000;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= nxt_state;
      instr       <= nxt_instr;
      pc          <= nxt_pc;
      wait_cnt    <= nxt_wait_cnt;
      code_addr   <= nxt_pc;
      code_rd_req <= (nxt_state == FETCH);
      load_en     <= nxt_load;
      save_en     <= nxt_save;
      alu_sel     <= nxt_alu;
      alu_order   <= nxt_instr[2:0];
      imm_sel     <= nxt_imm;
      imm_value   <= nxt_instr[5:0];
      busy        <= (nxt_state == FETCH) || nxt_exec;
      fault       <= (nxt_state == FAULT);
    end
  end

endmodule
